// File: rtl/mac_stream.sv
// mac_stream
//   Signed multiply-accumulate engine for one neuron. A job of no_of_inputs
//   (data, weight) pairs arrives on a valid/ready stream. One dot product is
//   returned on a valid/ready result port. There are two pipeline stages: the
//   product register, then the accumulator. The accumulator either saturates
//   or wraps on overflow. In both modes overflow sets a sticky flag.
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   start, no_of_inputs job request and length (sampled only in IDLE)
//   in_valid/in_ready   operand stream handshake; in_data, in_weight signed
//   result/result_valid/result_ready  dot product handshake
//   busy                high whenever the engine is not IDLE
//   overflow            sticky per job, cleared on accepted start
module mac_stream #(
  parameter int DATA_W   = 8,
  parameter int WGT_W    = 8,
  parameter int ACC_W    = 24,
  parameter int CNT_W    = 9,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  no_of_inputs,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [WGT_W-1:0]  in_weight,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              overflow
);

  localparam int PROD_W = DATA_W + WGT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                prod_vld_q, prod_vld_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [ACC_W-1:0]    result_q, result_d;

  logic [ACC_W:0]      sum_wide;
  logic                sum_ovf;
  logic [ACC_W-1:0]    acc_next;

  // The accumulator sum is one bit wider than the accumulator. When the top
  // two bits disagree, the true sum does not fit in ACC_W bits. In that case
  // the top bit gives the true sign of the sum, which selects the clamp rail.
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W + 1 - PROD_W){prod_q[PROD_W-1]}}, prod_q};
    sum_ovf  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    acc_next = sum_wide[ACC_W-1:0];
    if (sum_ovf && (SATURATE != 0)) begin
      acc_next = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // The accumulate stage consumes the previous cycle's product. The state
  // logic then may override acc and overflow when a new job starts.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    result_d   = result_q;

    if (prod_vld_q) begin
      acc_d = acc_next;
      if (sum_ovf) begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          rem_d = no_of_inputs;
          if (no_of_inputs == '0) begin
            state_d  = HOLD;
            result_d = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          prod_d     = PROD_W'($signed(in_data) * $signed(in_weight));
          prod_vld_d = 1'b1;
          rem_d      = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      // The last product lands in acc one cycle after entering DRAIN.
      // The result is captured on the cycle after that.
      DRAIN: begin
        if (!prod_vld_q) begin
          state_d  = HOLD;
          result_d = acc_q;
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
    end
  end

  assign in_ready     = (state_q == RUN);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == HOLD);
  assign result       = result_q;
  assign overflow     = ovf_q;

endmodule
